// File: rtl/pipe_reg_chain.sv
// Elastic register chain of DEPTH stages with per-stage valid/ready and bubble collapse.
// Optional saturating output-stall counter enabled by defining PIPE_REG_CHAIN_STALL_CNT_EN.
module pipe_reg_chain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [3:0]       occupancy
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    logic [WIDTH-1:0] data_p   [DEPTH];
    logic [WIDTH-1:0] data_src [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] vld_src;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] rdy;

    function automatic logic [3:0] popcnt(input logic [DEPTH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A stage can load when any stage from it to the output is empty or the output drains;
    // written non-recursively so each ready bit depends only on state and out_ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!vld_p[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        vld_src     = DEPTH'({vld_p, in_valid});
        data_src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_src[i] = data_p[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                vld_nxt[i] = 1'b0;
            end else if (rdy[i]) begin
                vld_nxt[i] = vld_src[i];
            end else begin
                vld_nxt[i] = vld_p[i];
            end
        end
    end

    // Stage registers: flush squashes valids but leaves data untouched.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            vld_p     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            vld_p     <= vld_nxt;
            occupancy <= popcnt(vld_nxt);
            for (int i = 0; i < DEPTH; i++) begin
                if (!flush && rdy[i]) begin
                    data_p[i] <= data_src[i];
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld_p[DEPTH-1];
    assign out_data  = data_p[DEPTH-1];

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: DEPTH=3 (unit 0) and DEPTH=1 (unit 1) instances, directed tables,
// corner sequences and queue-based random scoreboarding; stall counter checks when the macro is set.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [2];
    logic [15:0] idat [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [15:0] odat [2];
    logic        ordy [2];
    logic        fl   [2];
    logic [3:0]  occ  [2];
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    logic [15:0] scnt [2];
`endif

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(3)) dut3 (
        .Clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(odat[0]), .out_ready(ordy[0]), .flush(fl[0]),
        .occupancy(occ[0])
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
        , .stall_cnt(scnt[0])
`endif
    );

    pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) dut1 (
        .Clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(odat[1]), .out_ready(ordy[1]), .flush(fl[1]),
        .occupancy(occ[1])
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
        , .stall_cnt(scnt[1])
`endif
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        f;
        logic        exp_ir;
        logic        exp_ov;
        logic        chk_d;
        logic [15:0] exp_d;
        logic [3:0]  exp_occ;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        int          acc;
    } word_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic [15:0] d,
                         input logic r, input logic f);
        iv[u] = v; idat[u] = d; ordy[u] = r; fl[u] = f;
    endtask

    // Drive unit 0, sample in_ready before the edge, then step to just after the edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f,
                       output logic ir_seen);
        drive(0, v, d, r, f);
        #1;
        ir_seen = ir[0];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of accepted words with acceptance edge index. The front word is
    // never blocked until the last stage, so it is visible DEPTH edges after acceptance.
    task automatic run_random(input int u, input int depth, input int ncyc, input int flush_pct);
        word_t q[$];
        int    e;
        logic  m_ir, m_ov;
        word_t w;
        e = 0;
        for (int c = 0; c < ncyc; c++) begin
            drive(u, 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < flush_pct));
            #1;
            m_ir = !fl[u] && (q.size() < depth || ordy[u]);
            m_ov = (q.size() > 0) && (e - q[0].acc >= depth);
            chk("rnd_in_ready", ir[u], m_ir);
            chk("rnd_out_valid", ov[u], m_ov);
            chk("rnd_occupancy", occ[u], q.size());
            if (m_ov) chk("rnd_out_data", odat[u], q[0].d);
            if (fl[u]) begin
                q.delete();
            end else begin
                if (m_ov && ordy[u]) void'(q.pop_front());
                if (iv[u] && m_ir) begin
                    w.d = idat[u];
                    w.acc = e;
                    q.push_back(w);
                end
            end
            @(posedge clk);
            e++;
            #1;
        end
        drive(u, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    vec_t tbl[8];
    logic s;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        chk("rst_async_occ", occ[0], 4'd0);
        chk("rst_async_ov", ov[0], 1'b0);
        chk("rst_async_odat", odat[0], 16'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", ir[0], 1'b1);
        chk("rst_d1_in_ready", ir[1], 1'b1);

        // Streaming 0001..0005 with out_ready held high.
        tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd1};
        tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd2};
        tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd3};
        tbl[3] = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd3};
        tbl[4] = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 4'd3};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 4'd2};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 4'd1};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f, s);
            chk("stream_in_ready", s, tbl[i].exp_ir);
            chk("stream_out_valid", ov[0], tbl[i].exp_ov);
            chk("stream_occupancy", occ[0], tbl[i].exp_occ);
            if (tbl[i].chk_d) chk("stream_out_data", odat[0], tbl[i].exp_d);
        end

        // Backpressure: three words fill the chain, fourth waits for out_ready.
        cyc(1'b1, 16'hA001, 1'b0, 1'b0, s); chk("bp_ir1", s, 1'b1);
        cyc(1'b1, 16'hA002, 1'b0, 1'b0, s); chk("bp_occ2", occ[0], 4'd2);
        cyc(1'b1, 16'hA003, 1'b0, 1'b0, s); chk("bp_occ3", occ[0], 4'd3);
        chk("bp_head", odat[0], 16'hA001);
        cyc(1'b1, 16'hA004, 1'b0, 1'b0, s);
        chk("bp_full_ir", s, 1'b0);
        chk("bp_full_occ", occ[0], 4'd3);
        chk("bp_full_head", odat[0], 16'hA001);
        cyc(1'b1, 16'hA004, 1'b1, 1'b0, s);
        chk("bp_release_ir", s, 1'b1);
        chk("bp_drain_a2", odat[0], 16'hA002);
        chk("bp_drain_occ3", occ[0], 4'd3);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, s); chk("bp_drain_a3", odat[0], 16'hA003);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, s); chk("bp_drain_a4", odat[0], 16'hA004);
        chk("bp_drain_ov", ov[0], 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, s); chk("bp_empty_occ", occ[0], 4'd0);

        // Flush with two words held and BEEF offered in the same cycle.
        cyc(1'b1, 16'h1111, 1'b0, 1'b0, s);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0, s);
        chk("fl_pre_occ", occ[0], 4'd2);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, s);
        chk("fl_in_ready", s, 1'b0);
        chk("fl_occ", occ[0], 4'd0);
        chk("fl_ov", ov[0], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, s);
            chk("fl_no_beef", ov[0], 1'b0);
        end

        // Async reset between edges while full and stalled.
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, s);
        chk("ar_full", occ[0], 4'd3);
        rst_n = 1'b0;
        #1;
        chk("ar_ov", ov[0], 1'b0);
        chk("ar_odat", odat[0], 16'h0);
        chk("ar_occ", occ[0], 4'd0);
        #2 rst_n = 1'b1;
        cyc(1'b1, 16'h7777, 1'b1, 1'b0, s);
        chk("ar_first_ir", s, 1'b1);
        chk("ar_first_occ", occ[0], 4'd1);

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
        do_reset();
        cyc(1'b1, 16'h5555, 1'b0, 1'b0, s);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        chk("sc_start", scnt[0], 16'd0);
        repeat (10) cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        chk("sc_ten", scnt[0], 16'd10);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, s);
        chk("sc_flush_keeps", scnt[0], 16'd11);
        cyc(1'b1, 16'h6666, 1'b0, 1'b0, s);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        repeat (70000) cyc(1'b0, 16'h0, 1'b0, 1'b0, s);
        chk("sc_sat", scnt[0], 16'hFFFF);
`endif

        do_reset();
        run_random(0, 3, 1500, 4);
        do_reset();
        run_random(1, 1, 1000, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
